spi_peripheral: RTL and testbench

SPI mode-0 write-only target that produces the five control registers consumed by `pwm_peripheral`: output enables, PWM enables and duty cycle. Sits between the dedicated inputs `ui_in[2:0]` (SCLK, COPI, nCS) and the PWM block inside the top level. Replaces the constant `8'h00` register ties.

---
 rtl/spi_peripheral.sv | 130 +++++++++++++
 tb/tb_spi_peripheral.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target: synchronizes SCLK/COPI/nCS into clk and
// decodes 16-bit write frames into the five PWM control registers.
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int NREGS = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Bit 0 = SCLK, bit 1 = COPI, bit 2 = nCS.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [2:0]                  sync_last;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [NREGS-1:0][7:0] regs_q;
  logic        wr_strobe_q;

  logic sclk_rise, ncs_fall, ncs_rise, copi_s;
  logic frame_clr, shift_en, commit_ok;
  logic [6:0] addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= {ncs, copi, sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Chains reset low so a reset released with nCS already low yields no
  // falling edge; the partial frame is then never entered.
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sync_last[0] & ~prev_q[0];
  assign ncs_fall  = ~sync_last[2] & prev_q[2];
  assign ncs_rise  = sync_last[2] & ~prev_q[2];
  assign copi_s    = prev_q[1];
  assign addr      = shift_q[14:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An SCLK edge coinciding with the nCS rise is not counted.
  always_comb begin
    frame_clr = (state_q == IDLE) && ncs_fall;
    shift_en  = (state_q == SHIFT) && sclk_rise && !ncs_rise;
    commit_ok = (state_q == COMMIT) && (cnt_q == 5'd16) && shift_q[15] &&
                (addr <= MAX_ADDR) && (addr < 7'(NREGS));
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (frame_clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[14:0], copi_s};
      if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= commit_ok;
      if (commit_ok) begin
        case (addr)
          7'd0:    regs_q[0] <= shift_q[7:0];
          7'd1:    regs_q[1] <= shift_q[7:0];
          7'd2:    regs_q[2] <= shift_q[7:0];
          7'd3:    regs_q[3] <= shift_q[7:0];
          7'd4:    regs_q[4] <= shift_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed and random SPI frames against a
// register-map model of the frame rules.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  spi_peripheral dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int strobe_cnt = 0;
  int last_strobe_cyc = -1;
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_regs [5];
  int         exp_strobes = 0;
  int         rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clkn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, " out_7_0"},  {24'h0, en_reg_out_7_0},  {24'h0, exp_regs[0]});
    check({tag, " out_15_8"}, {24'h0, en_reg_out_15_8}, {24'h0, exp_regs[1]});
    check({tag, " pwm_7_0"},  {24'h0, en_reg_pwm_7_0},  {24'h0, exp_regs[2]});
    check({tag, " pwm_15_8"}, {24'h0, en_reg_pwm_15_8}, {24'h0, exp_regs[3]});
    check({tag, " duty"},     {24'h0, pwm_duty_cycle},  {24'h0, exp_regs[4]});
    check({tag, " strobes"},  strobe_cnt, exp_strobes);
  endtask

  // Reference: only a complete 16-bit write to an existing address lands;
  // a reset anywhere in the frame clears every register instead.
  task automatic model(input logic [31:0] w, input int nbits, input bit rst_mid,
                       output bit committed);
    committed = 1'b0;
    if (rst_mid) begin
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    end else if (nbits == 16 && w[15] && w[14:8] <= 7'd4) begin
      exp_regs[w[10:8]] = w[7:0];
      exp_strobes++;
      committed = 1'b1;
    end
  endtask

  // SCLK = clk/8, bits MSB first; optional reset pulse after bit rst_after.
  task automatic send_frame(input logic [31:0] w, input int nbits,
                            input int rst_after, input int gap);
    ncs = 1'b0;
    clkn(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = w[i];
      clkn(4);
      sclk = 1'b1;
      clkn(4);
      sclk = 1'b0;
      if (rst_after == nbits - i) begin
        clkn(1);
        rst = 1'b1;
        clkn(2);
        rst = 1'b0;
      end
    end
    clkn(4);
    ncs = 1'b1;
    rise_cyc = cyc;
    clkn(gap);
  endtask

  task automatic do_frame(input string tag, input logic [31:0] w, input int nbits,
                          input int rst_after);
    bit committed;
    send_frame(w, nbits, rst_after, 8);
    model(w, nbits, rst_after > 0, committed);
    check_all(tag);
    check({tag, " strobe idle"}, {31'h0, wr_strobe}, 32'h0);
    if (committed) check({tag, " latency"}, last_strobe_cyc - rise_cyc, 4);
  endtask

  initial begin
    logic [31:0] w;
    int          nb, r, gap;
    bit          c;

    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

    // Reset with random pins
    rst  = 1'b1;
    sclk = 1'($urandom_range(0, 1));
    copi = 1'($urandom_range(0, 1));
    ncs  = 1'($urandom_range(0, 1));
    clkn(3);
    check_all("reset");
    check("reset strobe", {31'h0, wr_strobe}, 32'h0);
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    clkn(2);
    rst = 1'b0;
    clkn(6);
    check_all("post reset");

    // Single writes
    do_frame("wr00", 32'h80F0, 16, 0);
    do_frame("wr04", 32'h8480, 16, 0);

    // Discarded frames
    do_frame("read", 32'h00AA, 16, 0);
    do_frame("addr05", {16'h0, 8'h85, 8'($urandom)}, 16, 0);
    do_frame("addr7f", {16'h0, 8'hFF, 8'($urandom)}, 16, 0);

    // Wrong length
    do_frame("len15", 32'h82FF >> 1, 15, 0);
    do_frame("len17", {15'h0, 16'h82FF, 1'b1}, 17, 0);

    // Reset mid-frame, then the same frame completes
    do_frame("rstmid", 32'h8155, 16, 8);
    do_frame("after rst", 32'h8155, 16, 0);

    // Back-to-back with minimum gap
    for (int a = 0; a < 5; a++) begin
      w = {16'h0, 1'b1, 7'(a), 8'(1 << a)};
      send_frame(w, 16, 0, 3);
      model(w, 16, 1'b0, c);
    end
    clkn(8);
    check_all("b2b");

    // Random frames
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 7);
      w = {16'h0, 1'($urandom_range(0, 3) != 0),
           (r == 7) ? 7'h7F : 7'($urandom_range(0, 7)), 8'($urandom)};
      nb = 16;
      if (r == 0) begin
        nb = 15;
        w = w >> 1;
      end else if (r == 1) begin
        nb = 17;
        w = {w[30:0], 1'($urandom_range(0, 1))};
      end
      gap = $urandom_range(3, 6);
      send_frame(w, nb, 0, gap);
      model(w, nb, 1'b0, c);
      clkn(6);
      check_all("rand");
      if (c) check("rand latency", last_strobe_cyc - rise_cyc, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
